mult_div_seq: RTL and testbench

- Iterative 32-bit multiply/divide unit for MIPS mult/multu/div/divu.
- Replaces the combinational multiply/divide path between register-file read and the Lo/Hi register.
- Operands are captured on a start pulse and processed one bit per cycle.
- A done pulse is emitted that serves directly as the Lo/Hi write enable. result[63:32] goes to Hi and result[31:0] to Lo.

---
 rtl/mult_div_seq.sv | 126 ++++++++++++
 tb/tb_mult_div_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit for MIPS mult/multu/div/divu, one bit per cycle.
// Optional MD_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mult_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_mult,
  input  logic               is_unsigned,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic               mult_q, neg_q_q, neg_r_q, bzero_q;
  logic [WIDTH-1:0]   a_raw_q, quo_q;
  logic [2*WIDTH-1:0] acc_q, opa_q;
  logic [WIDTH:0]     opb_q;
  logic [2*WIDTH-1:0] result_q;
  logic               dbz_q;

  logic               accept, calc_last;
  logic               a_neg, b_neg;
  logic [WIDTH:0]     a_mag, b_mag;
  logic [WIDTH:0]     rem_sh, rem_nx;
  logic               sub_ok;
  logic [2*WIDTH-1:0] prod_fx;
  logic [WIDTH-1:0]   quo_fx, rem_fx;

  assign accept = start && (state_q == StIdle || state_q == StDone);

  // Magnitudes are WIDTH+1 bits so the most negative operand keeps its full value.
  assign a_neg  = !is_unsigned && a[WIDTH-1];
  assign b_neg  = !is_unsigned && b[WIDTH-1];
  assign a_mag  = a_neg ? (~{1'b1, a} + 1'b1) : {1'b0, a};
  assign b_mag  = b_neg ? (~{1'b1, b} + 1'b1) : {1'b0, b};

  // Restoring division step; the remainder lives in the low WIDTH+1 bits of acc_q.
  assign rem_sh = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
  assign sub_ok = rem_sh >= opb_q;
  assign rem_nx = sub_ok ? (rem_sh - opb_q) : rem_sh;

`ifdef MD_EARLY_OUT_EN
  assign calc_last = (cnt_q == CntW'(WIDTH - 1)) || (mult_q && opb_q[WIDTH:1] == '0);
`else
  assign calc_last = (cnt_q == CntW'(WIDTH - 1));
`endif

  assign prod_fx = neg_q_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fx  = bzero_q ? '1 : (neg_q_q ? (~quo_q + 1'b1) : quo_q);
  assign rem_fx  = bzero_q ? a_raw_q
                           : (neg_r_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (calc_last) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mult_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      a_raw_q  <= '0;
      quo_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        mult_q  <= is_mult;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        bzero_q <= !is_mult && (b == '0);
        a_raw_q <= a;
        quo_q   <= '0;
        acc_q   <= '0;
        opa_q   <= {{(WIDTH-1){1'b0}}, a_mag};
        opb_q   <= b_mag;
        dbz_q   <= 1'b0;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + 1'b1;
        opa_q <= opa_q << 1;
        if (mult_q) begin
          if (opb_q[0]) acc_q <= acc_q + opa_q;
          opb_q <= opb_q >> 1;
        end else begin
          acc_q <= {{(WIDTH-1){1'b0}}, rem_nx};
          quo_q <= {quo_q[WIDTH-2:0], sub_ok};
        end
      end else if (state_q == StFixup) begin
        result_q <= mult_q ? prod_fx : {rem_fx, quo_fx};
        dbz_q    <= bzero_q;
      end
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StFixup);
  assign done        = (state_q == StDone);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_mult_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_mult, is_unsigned;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t scb[$];

  mult_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .is_mult     (is_mult),
    .is_unsigned (is_unsigned),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference model straight from the arithmetic definition of each MIPS op.
  function automatic exp_t model(logic [31:0] ma, logic [31:0] mb, logic m, logic u);
    exp_t           e;
    longint         sa, sbv, q, r;
    longint unsigned ua, ub, mag;
    int             msb;
    sa  = longint'($signed(ma));
    sbv = longint'($signed(mb));
    ua  = {32'b0, ma};
    ub  = {32'b0, mb};
    e.dbz = 1'b0;
    e.lat = 34;
    e.start_cyc = 0;
    if (m) begin
      e.res = u ? 64'(ua * ub) : 64'(sa * sbv);
    end else if (mb == 32'd0) begin
      e.res = {ma, 32'hFFFF_FFFF};
      e.dbz = 1'b1;
    end else begin
      if (u) begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
      end else begin
        q = sa / sbv;
        r = sa % sbv;
      end
      e.res = {r[31:0], q[31:0]};
    end
`ifdef MD_EARLY_OUT_EN
    if (m) begin
      mag = (u || sbv >= 0) ? ub : longint'(-sbv);
      msb = -1;
      for (int i = 0; i < 33; i++) if (mag[i]) msb = i;
      e.lat = ((msb + 1) > 1 ? (msb + 1) : 1) + 2;
    end
`else
    mag = 0;
    msb = mag[0] ? 1 : 0;
    if (msb != 0) e.lat = 0;
`endif
    return e;
  endfunction

  task automatic monitor();
    logic [63:0] held;
    exp_t        e;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (busy) chk("hold_while_busy", result, held);
      else held = result;
      if (done) begin
        if (scb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: result %h with nothing pending (cycle %0d)", result, cyc);
        end else begin
          e = scb.pop_front();
          chk("result", result, e.res);
          chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
          chk("latency", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
        end
      end
    end
  endtask

  task automatic issue(logic [31:0] ia, logic [31:0] ib, logic m, logic u);
    exp_t e;
    a = ia;
    b = ib;
    is_mult = m;
    is_unsigned = u;
    start = 1'b1;
    e = model(ia, ib, m, u);
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    scb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: done still 0, expected 1 within 200 cycles");
    end
  endtask

  logic [31:0] da [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd10, 32'h8000_0000,
                           32'd9, 32'd0, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
  logic [31:0] db [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd3, 32'hFFFF_FFFF,
                           32'd1, 32'd0, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0};
  logic        dm [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        du [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    is_mult = 1'b0;
    is_unsigned = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_dbz", {63'b0, div_by_zero}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corners, issued back-to-back from DONE.
    for (int i = 0; i < 12; i++) begin
      issue(da[i], db[i], dm[i], du[i]);
      wait_done();
    end

    // A start while busy must not recapture operands.
    @(posedge clk);
    #1;
    issue(32'd3, 32'd5, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    a = 32'd100;
    b = 32'd7;
    is_mult = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset mid-CALC aborts and clears everything on the next cycle.
    issue(32'd1234, 32'd77, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    scb.delete();
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_dbz", {63'b0, div_by_zero}, 64'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Randomized mix with biased corner operands.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(15);
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
      wait_done();
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(scb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
